reg_file_rename: RTL and testbench

Architectural register file with per-register rename tags for the out-of-order core.
- Sits between the decoder (issue/rename, operand query) and the ROB (in-order commit, flush).
- Decoder asks it for each source operand; answer is either a ready value or the ROB id that will produce it.
- ROB commits write values here and retire tags; a ROB clear drops all pending renames.

---
 rtl/reg_file_rename.sv | 121 ++++++++++++
 tb/tb_reg_file_rename.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// reg_file_rename
//   Architectural register file with a rename tag per register. The decoder
//   renames destinations (issue) and asks about source operands (qry1/qry2).
//   The ROB writes results in order (commit) and can drop all renames
//   (rob_clear). A query answers one of two ways. It either returns a ready
//   value, or it returns the ROB id of the entry that will produce the value.
//
// Ports
//   clk_in, rst_in         clock; asynchronous active-high reset
//   rdy_in                 low = hold every register (queries still answer)
//   issue_valid/rd/rob_id  rename a destination to a ROB entry
//   qryN_reg               source register to look up (N = 1, 2)
//   qryN_busy/rob_id/value lookup result: pending + producer, or ready value
//   commit_valid/rd/rob_id/value  in-order write-back from the ROB
//   rob_clear              flush: clear every busy bit, discard same-cycle issue

module reg_file_rename #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int REG_NUM      = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [ROB_SIZE_BIT-1:0] issue_rob_id,
    input  logic [4:0]              qry1_reg,
    output logic                    qry1_busy,
    output logic [ROB_SIZE_BIT-1:0] qry1_rob_id,
    output logic [31:0]             qry1_value,
    input  logic [4:0]              qry2_reg,
    output logic                    qry2_busy,
    output logic [ROB_SIZE_BIT-1:0] qry2_rob_id,
    output logic [31:0]             qry2_value,
    input  logic                    commit_valid,
    input  logic [4:0]              commit_rd,
    input  logic [ROB_SIZE_BIT-1:0] commit_rob_id,
    input  logic [31:0]             commit_value,
    input  logic                    rob_clear
);

    logic [31:0]             r_value [REG_NUM];
    logic [REG_NUM-1:0]      r_busy;
    logic [ROB_SIZE_BIT-1:0] r_tag   [REG_NUM];

    logic                    w_commit_en;
    logic                    w_issue_en;

    logic [4:0]              w_qry_reg   [2];
    logic                    w_qry_busy  [2];
    logic [ROB_SIZE_BIT-1:0] w_qry_rob   [2];
    logic [31:0]             w_qry_value [2];

    // x0 is never written or renamed. A flush also kills any issue in the
    // same cycle.
    assign w_commit_en = rdy_in & commit_valid & (commit_rd != 5'd0);
    assign w_issue_en  = rdy_in & issue_valid & (issue_rd != 5'd0) & ~rob_clear;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            // The value is always written. The busy bit is released only if
            // this commit is still the newest rename of rd.
            if (w_commit_en) begin
                r_value[commit_rd] <= commit_value;
                if (r_tag[commit_rd] == commit_rob_id) begin
                    r_busy[commit_rd] <= 1'b0;
                end
            end
            // Tags are left stale on a flush. Nothing reads them while busy is clear.
            if (rob_clear) begin
                r_busy <= '0;
            end
            // This comes last so that a same-cycle issue to rd overrides
            // the commit's busy release.
            if (w_issue_en) begin
                r_busy[issue_rd] <= 1'b1;
                r_tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    assign w_qry_reg[0] = qry1_reg;
    assign w_qry_reg[1] = qry2_reg;

    // A lookup ignores a same-cycle issue. It does forward a same-cycle
    // commit from the entry that currently owns the register.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_qry_busy[p]  = 1'b0;
            w_qry_rob[p]   = '0;
            w_qry_value[p] = '0;
            if (w_qry_reg[p] != 5'd0) begin
                if (r_busy[w_qry_reg[p]]) begin
                    if (commit_valid && (commit_rd == w_qry_reg[p]) &&
                        (commit_rob_id == r_tag[w_qry_reg[p]])) begin
                        w_qry_value[p] = commit_value;
                    end else begin
                        w_qry_busy[p] = 1'b1;
                        w_qry_rob[p]  = r_tag[w_qry_reg[p]];
                    end
                end else begin
                    w_qry_value[p] = r_value[w_qry_reg[p]];
                end
            end
        end
    end

    assign qry1_busy   = w_qry_busy[0];
    assign qry1_rob_id = w_qry_rob[0];
    assign qry1_value  = w_qry_value[0];
    assign qry2_busy   = w_qry_busy[1];
    assign qry2_rob_id = w_qry_rob[1];
    assign qry2_value  = w_qry_value[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename
//   Directed stimulus for reg_file_rename. Each check pushes the expected
//   {busy, rob_id, value} for both query ports into a scoreboard queue.
//   A monitor on the falling clock edge pops the entries and compares them.

module tb_reg_file_rename;

    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [RB-1:0] issue_rob_id;
    logic [4:0]    qry1_reg;
    logic          qry1_busy;
    logic [RB-1:0] qry1_rob_id;
    logic [31:0]   qry1_value;
    logic [4:0]    qry2_reg;
    logic          qry2_busy;
    logic [RB-1:0] qry2_rob_id;
    logic [31:0]   qry2_value;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [RB-1:0] commit_rob_id;
    logic [31:0]   commit_value;
    logic          rob_clear;

    reg_file_rename #(.ROB_SIZE_BIT(RB), .REG_NUM(32)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .qry1_reg      (qry1_reg),
        .qry1_busy     (qry1_busy),
        .qry1_rob_id   (qry1_rob_id),
        .qry1_value    (qry1_value),
        .qry2_reg      (qry2_reg),
        .qry2_busy     (qry2_busy),
        .qry2_rob_id   (qry2_rob_id),
        .qry2_value    (qry2_value),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .rob_clear     (rob_clear)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string           nm;
        logic [RB+32:0]  e1;
        logic [RB+32:0]  e2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t m_e;
    logic [RB+32:0] m_a1, m_a2;

    always @(negedge clk_in) begin
        while (sb.size() > 0) begin
            m_e  = sb.pop_front();
            m_a1 = {qry1_busy, qry1_rob_id, qry1_value};
            m_a2 = {qry2_busy, qry2_rob_id, qry2_value};
            n_cmp++;
            if (m_a1 !== m_e.e1 || m_a2 !== m_e.e2) begin
                n_bad++;
                $display("FAIL %s: got q1=%h q2=%h, want q1=%h q2=%h ({busy,rob,value})",
                         m_e.nm, m_a1, m_a2, m_e.e1, m_e.e2);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        rob_clear    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RB-1:0] id);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [RB-1:0] id, input logic [31:0] v);
        commit_valid  = 1'b1;
        commit_rd     = rd;
        commit_rob_id = id;
        commit_value  = v;
    endtask

    task automatic chk(input string nm,
                       input logic [4:0] r1, input logic b1, input logic [RB-1:0] i1, input logic [31:0] v1,
                       input logic [4:0] r2, input logic b2, input logic [RB-1:0] i2, input logic [31:0] v2);
        exp_t e;
        qry1_reg = r1;
        qry2_reg = r2;
        e.nm = nm;
        e.e1 = {b1, i1, v1};
        e.e2 = {b2, i2, v2};
        sb.push_back(e);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
        rob_clear = 1'b0; qry1_reg = '0; qry2_reg = '0;
        #1;
        chk("in_reset",   5, 0, 0, 0,  0, 0, 0, 0);
        step(); rst_in = 1'b0;
        chk("post_reset", 5, 0, 0, 0,  0, 0, 0, 0);

        step(); commit(0, 0, 32'hDEADBEEF);
        chk("x0_commit",  0, 0, 0, 0,  0, 0, 0, 0);
        step();
        chk("x0_after",   0, 0, 0, 0,  5, 0, 0, 0);

        step(); issue(3, 2);
        chk("x3_same_cycle_issue", 3, 0, 0, 0,  0, 0, 0, 0);
        step();
        chk("x3_busy",    3, 1, 2, 0,  0, 0, 0, 0);
        step(); commit(3, 2, 32'h1234);
        chk("x3_forward", 3, 0, 0, 32'h1234,  0, 0, 0, 0);
        step();
        chk("x3_commit",  3, 0, 0, 32'h1234,  0, 0, 0, 0);

        step(); issue(4, 1);
        step(); issue(4, 5);
        step(); commit(4, 1, 32'd7);
        chk("x4_stale_commit", 4, 1, 5, 0,  3, 0, 0, 32'h1234);
        step();
        chk("x4_still_busy",   4, 1, 5, 0,  0, 0, 0, 0);
        step(); commit(4, 5, 32'd9);
        step();
        chk("x4_done",         4, 0, 0, 32'd9,  0, 0, 0, 0);

        step(); issue(6, 0);
        step(); issue(6, 3); commit(6, 0, 32'hAA);
        chk("x6_fwd_same",     6, 0, 0, 32'hAA,  4, 0, 0, 32'd9);
        step();
        chk("x6_issue_wins",   6, 1, 3, 0,  0, 0, 0, 0);
        step(); commit(6, 3, 32'hBB);
        step();
        chk("x6_done",         6, 0, 0, 32'hBB,  0, 0, 0, 0);

        step(); commit(2, 0, 32'h22);
        step(); issue(1, 1);
        step(); issue(2, 2);
        step(); rob_clear = 1'b1; commit(1, 1, 32'h55); issue(7, 3);
        step();
        chk("clear_x1_x2",     1, 0, 0, 32'h55,  2, 0, 0, 32'h22);
        step();
        chk("clear_x7",        7, 0, 0, 0,  3, 0, 0, 32'h1234);

        step(); rdy_in = 1'b0; issue(8, 4); commit(9, 0, 32'd1);
        step(); rdy_in = 1'b1;
        chk("rdy_hold",        8, 0, 0, 0,  9, 0, 0, 0);

        step(); issue(5, 6);
        step();
        chk("x5_busy",         5, 1, 6, 0,  3, 0, 0, 32'h1234);
        step(); rst_in = 1'b1;
        chk("reset_mid",       5, 0, 0, 0,  3, 0, 0, 0);
        step(); rst_in = 1'b0;
        chk("after_reset_mid", 5, 0, 0, 0,  3, 0, 0, 0);

        step();
        step();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
